// File: rtl/func_input_ctrl_pkg.sv
// Shared types and bit positions for the push-button / switch front end.
package func_input_pkg;

  // Active display function; the fourth encoding is never entered in normal operation.
  typedef enum logic [1:0] {
    F1        = 2'd0,
    F2        = 2'd1,
    F3        = 2'd2,
    F_ILLEGAL = 2'd3
  } func_state_e;

  localparam int unsigned NUM_FUNCS = 3;

  // func1_instruction = {SW3, SW2, SW1, East}
  localparam int F1_EAST  = 0;
  localparam int F1_SW1   = 1;
  localparam int F1_SW2   = 2;
  localparam int F1_SW3   = 3;

  // func2_instruction = {SW3, East, West, North, South}
  localparam int F2_SOUTH = 0;
  localparam int F2_NORTH = 1;
  localparam int F2_WEST  = 2;
  localparam int F2_EAST  = 3;
  localparam int F2_SW3   = 4;

  // func3_instruction = {East, West, North, South, SW3}
  localparam int F3_SW3   = 0;
  localparam int F3_SOUTH = 1;
  localparam int F3_NORTH = 2;
  localparam int F3_WEST  = 3;
  localparam int F3_EAST  = 4;

  // Round-robin successor; the last legal function and the illegal code both wrap to F1.
  function automatic func_state_e next_func(input func_state_e s);
    if (s >= func_state_e'(2'(NUM_FUNCS - 1))) begin
      return F1;
    end
    return func_state_e'(s + 2'd1);
  endfunction

endpackage

// File: rtl/func_input_ctrl_if.sv
// Raw board inputs and per-function instruction outputs of the front end.
interface func_input_ctrl_if;
  logic       East;
  logic       West;
  logic       North;
  logic       South;
  logic       change;
  logic       SW1;
  logic       SW2;
  logic       SW3;
  logic [1:0] func_index;
  logic [3:0] func1_instruction;
  logic [4:0] func2_instruction;
  logic [4:0] func3_instruction;
  logic       func_changed;

  modport master (
    output East, West, North, South, change, SW1, SW2, SW3,
    input  func_index, func1_instruction, func2_instruction, func3_instruction, func_changed
  );

  modport slave (
    input  East, West, North, South, change, SW1, SW2, SW3,
    output func_index, func1_instruction, func2_instruction, func3_instruction, func_changed
  );
endinterface

// File: rtl/func_input_ctrl_debounce_cell.sv
// One button: 2-flop synchronizer, stable-count debounce and rising-edge pulse.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             db_q, db_d;
  // db delayed by one cycle, used only for edge detection
  logic             db_dly_q, db_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: count consecutive cycles the synchronized level disagrees with db.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    cnt_d    = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers, cleared asynchronously so a reset mid-debounce restarts cleanly.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse = db_q & ~db_dly_q;

endmodule

// File: rtl/func_input_ctrl.sv
// Button/switch front end: debounced pulses, function sequencer, registered instruction buses.
module func_input_ctrl
  import func_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic              sysclk,
  input logic              reset_n,
  func_input_ctrl_if.slave io
);

  localparam int BTN_EAST   = 0;
  localparam int BTN_WEST   = 1;
  localparam int BTN_NORTH  = 2;
  localparam int BTN_SOUTH  = 3;
  localparam int BTN_CHANGE = 4;

  logic [4:0] btn_raw;
  logic [4:0] btn_pulse;
  logic       change_pulse;

  logic [2:0] sw_s1_q, sw_s1_d;
  logic [2:0] sw_s2_q, sw_s2_d;

  func_state_e state_q, state_d;
  logic        changed_q, changed_d;
  logic [3:0]  f1_instr_q, f1_instr_d;
  logic [4:0]  f2_instr_q, f2_instr_d;
  logic [4:0]  f3_instr_q, f3_instr_d;

  assign btn_raw = {io.change, io.South, io.North, io.West, io.East};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .sysclk  (sysclk),
      .reset_n (reset_n),
      .raw     (btn_raw[i]),
      .pulse   (btn_pulse[i])
    );
  end

  assign change_pulse = btn_pulse[BTN_CHANGE];

  // Switch synchronizer next-state; switches are levels and need no debounce.
  always_comb begin
    sw_s1_d = {io.SW3, io.SW2, io.SW1};
    sw_s2_d = sw_s1_q;
  end

  // Function FSM next state; the illegal code recovers to F1 on its own.
  always_comb begin
    state_d = state_q;
    if (change_pulse || (state_q == F_ILLEGAL)) begin
      state_d = next_func(state_q);
    end
    changed_d = (state_d != state_q);
  end

  // Instruction buses for the function active next cycle; a change press blanks all of them.
  always_comb begin
    f1_instr_d = '0;
    f2_instr_d = '0;
    f3_instr_d = '0;
    if (!change_pulse) begin
      case (state_d)
        F1: begin
          f1_instr_d[F1_EAST] = btn_pulse[BTN_EAST];
          f1_instr_d[F1_SW1]  = sw_s2_q[0];
          f1_instr_d[F1_SW2]  = sw_s2_q[1];
          f1_instr_d[F1_SW3]  = sw_s2_q[2];
        end
        F2: begin
          f2_instr_d[F2_SOUTH] = btn_pulse[BTN_SOUTH];
          f2_instr_d[F2_NORTH] = btn_pulse[BTN_NORTH];
          f2_instr_d[F2_WEST]  = btn_pulse[BTN_WEST];
          f2_instr_d[F2_EAST]  = btn_pulse[BTN_EAST];
          f2_instr_d[F2_SW3]   = sw_s2_q[2];
        end
        F3: begin
          f3_instr_d[F3_SW3]   = sw_s2_q[2];
          f3_instr_d[F3_SOUTH] = btn_pulse[BTN_SOUTH];
          f3_instr_d[F3_NORTH] = btn_pulse[BTN_NORTH];
          f3_instr_d[F3_WEST]  = btn_pulse[BTN_WEST];
          f3_instr_d[F3_EAST]  = btn_pulse[BTN_EAST];
        end
        default: ;
      endcase
    end
  end

  // State, switch synchronizer and output registers.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      state_q    <= F1;
      changed_q  <= 1'b0;
      f1_instr_q <= '0;
      f2_instr_q <= '0;
      f3_instr_q <= '0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      state_q    <= state_d;
      changed_q  <= changed_d;
      f1_instr_q <= f1_instr_d;
      f2_instr_q <= f2_instr_d;
      f3_instr_q <= f3_instr_d;
    end
  end

  assign io.func_index        = state_q;
  assign io.func_changed      = changed_q;
  assign io.func1_instruction = f1_instr_q;
  assign io.func2_instruction = f2_instr_q;
  assign io.func3_instruction = f3_instr_q;

endmodule
